decoder_3to8_scan: RTL
======================

// Module: decoder_3to8_scan
// PURPOSE
//  Registered 3-to-8 one-hot decoder: the inverse of the 8-to-3 encoder.
//  Direct mode: accepts a 3-bit code over a valid/ready handshake and drives
//   the matching one-hot line for a programmable number of cycles.
//  Scan mode: free-runs through all 8 lines in order.
//  Drives LED rows / digit selects in the lab boards, and closes the
//   encoder->decoder loopback.
// PARAMETERS
//  HOLD_CYCLES  4  cycles each one-hot output is held (direct and scan); 0 is treated as 1
//  HOLD_W       8  width of the internal hold counter; must hold HOLD_CYCLES-1
// PORTS
//  clk         in   1  single clock, all logic on rising edge
//  rst_n       in   1  asynchronous reset, active-low
//  en          in   1  block enable; low forces IDLE
//  mode        in   1  0 = direct decode, 1 = scan
//  code_in     in   3  code to decode (direct mode)
//  code_valid  in   1  code_in valid
//  code_ready  out  1  block can accept code_in this cycle
//  data_out    out  8  registered one-hot output; 8'h00 when inactive
//  code_cur    out  3  code currently driven on data_out
//  out_valid   out  1  data_out holds an active one-hot value
//  scan_wrap   out  1  1-cycle pulse when scan wraps from line 7 to line 0
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; data_out=8'h00; code_cur=0; out_valid=0;
//   scan_wrap=0; counter=0. code_ready is combinational and is 0 during reset.
//  Encoding: data_out = 8'b1 << code_cur whenever out_valid=1; 8'h00 otherwise.
//   data_out never has more than one bit set.
//  States: IDLE, HOLD, SCAN.
//  IDLE:
//   code_ready = en & ~mode.
//   en & ~mode & code_valid -> handshake at edge k: latch code_in, load
//    counter=HOLD_CYCLES-1, go to HOLD. data_out is valid from cycle k+1
//    (1-cycle latency).
//   en & mode -> go to SCAN at the next edge with code_cur=0 and data_out=8'h01.
//  HOLD:
//   code_ready=0; input is ignored.
//   Counter decrements each cycle. At counter==0 -> IDLE and data_out=0.
//   The output is therefore high for exactly HOLD_CYCLES cycles.
//   No back-to-back accept in the same cycle as release; the minimum code
//    period is HOLD_CYCLES+1.
//  SCAN:
//   code_ready=0.
//   Counter reloads at each slot boundary; code_cur increments mod 8.
//   On the 7->0 transition, scan_wrap=1 for exactly the cycle in which
//    data_out first shows 8'h01.
//   If mode is deasserted, the current slot completes, then -> IDLE at the
//    slot boundary (data_out=0). It does not advance to the next line.
//  en=0 in any state: next edge -> IDLE, data_out=0, out_valid=0, scan_wrap=0.
//   This takes priority over every other transition.
//  Asserting rst_n mid-HOLD/SCAN: outputs clear immediately (async). Operation
//   restarts from IDLE; no pending code is retained.
//  mode changes during HOLD have no effect until HOLD ends. With mode=1 at
//   release, the next state is IDLE, then SCAN on the following edge.
//  code_in is sampled only on a handshake; X on code_in outside a handshake
//   must not propagate.
// TESTING
//  1 Reset: rst_n=0 asynchronously mid-cycle -> data_out=00, out_valid=0,
//    code_ready=0 at once. Release with en=1, mode=0 -> code_ready=1.
//  2 Direct, HOLD_CYCLES=4: code_in=5 with a 1-cycle valid -> data_out=8'h20,
//    code_cur=5 for exactly 4 cycles starting 1 cycle later. Then 8'h00 and
//    code_ready=1 again.
//  3 Exhaustive direct: codes 0..7 back-to-back with code_valid held high ->
//    outputs 01,02,04,...,80. Each accepted only when code_ready=1; period=5 cycles.
//  4 Scan, HOLD_CYCLES=2: mode=1 -> sequence 01,01,02,02,...,80,80,01. scan_wrap
//    high only in the first 01 cycle after 80. Repeat for 2 full wraps.
//  5 Scan exit: drop mode while data_out=8'h08 -> 8'h08 finishes its slot,
//    then 8'h00. State returns to IDLE, not 8'h10.
//  6 Abort: en=0 during HOLD of code 3 and during SCAN -> data_out=00 on the
//    next edge. Async rst_n pulse during SCAN -> immediate clear; restart scan
//    at 8'h01.

Source files
------------

// File: rtl/decoder_3to8_scan_if.sv
// Handshake and output bundle for the registered 3-to-8 scan decoder.
// master drives code/control, slave is the decoder itself.
interface decoder_3to8_scan_if;
   logic       en;
   logic       mode;
   logic [2:0] code_in;
   logic       code_valid;
   logic       code_ready;
   logic [7:0] data_out;
   logic [2:0] code_cur;
   logic       out_valid;
   logic       scan_wrap;

   modport master (
      output en,
      output mode,
      output code_in,
      output code_valid,
      input  code_ready,
      input  data_out,
      input  code_cur,
      input  out_valid,
      input  scan_wrap
   );

   modport slave (
      input  en,
      input  mode,
      input  code_in,
      input  code_valid,
      output code_ready,
      output data_out,
      output code_cur,
      output out_valid,
      output scan_wrap
   );
endinterface

// File: rtl/decoder_3to8_scan.sv
// Registered 3-to-8 one-hot decoder with a direct (handshake) mode
// and a free-running scan mode; each line is held HOLD_CYCLES cycles.
module decoder_3to8_scan #(
   parameter int HOLD_CYCLES = 4,
   parameter int HOLD_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   decoder_3to8_scan_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_SCAN
   } state_t;

   // a hold of zero cycles would never show the line, so clamp to one
   localparam int HC = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
   localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HC - 1);

   state_t            r_state;
   state_t            w_state_nx;
   logic [HOLD_W-1:0] r_cnt;
   logic [HOLD_W-1:0] w_cnt_nx;
   logic [2:0]        r_code;
   logic [2:0]        w_code_nx;
   logic              r_valid;
   logic              w_valid_nx;
   logic              r_wrap;
   logic              w_wrap_nx;
   logic [7:0]        r_data;
   logic [7:0]        w_data_nx;
   logic              w_ready;
   logic              w_accept;
   logic              w_cnt_zero;

   assign w_ready = rst_n & bus.en & ~bus.mode
                  & (r_state == S_IDLE);
   assign w_accept   = w_ready & bus.code_valid;
   assign w_cnt_zero = (r_cnt == '0);

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_code_nx  = r_code;
      w_valid_nx = r_valid;
      w_wrap_nx  = 1'b0;
      if (!bus.en) begin
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
         w_valid_nx = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.mode) begin
                  w_state_nx = S_SCAN;
                  w_code_nx  = 3'd0;
                  w_cnt_nx   = RELOAD;
                  w_valid_nx = 1'b1;
               end else if (w_accept) begin
                  w_state_nx = S_HOLD;
                  w_code_nx  = bus.code_in;
                  w_cnt_nx   = RELOAD;
                  w_valid_nx = 1'b1;
               end
            end
            S_HOLD: begin
               if (w_cnt_zero) begin
                  w_state_nx = S_IDLE;
                  w_valid_nx = 1'b0;
               end else begin
                  w_cnt_nx = r_cnt - 1'b1;
               end
            end
            S_SCAN: begin
               if (!w_cnt_zero) begin
                  w_cnt_nx = r_cnt - 1'b1;
               end else if (bus.mode) begin
                  w_code_nx = 3'(r_code + 3'd1);
                  w_cnt_nx  = RELOAD;
                  w_wrap_nx = (r_code == 3'd7);
               end else begin
                  // scan released: finish on this line, do not advance
                  w_state_nx = S_IDLE;
                  w_valid_nx = 1'b0;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
               w_valid_nx = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_data_nx = 8'h00;
      if (w_valid_nx) begin
         w_data_nx = 8'h01 << w_code_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_code  <= 3'd0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         r_data  <= 8'h00;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_code  <= w_code_nx;
         r_valid <= w_valid_nx;
         r_wrap  <= w_wrap_nx;
         r_data  <= w_data_nx;
      end
   end

   assign bus.code_ready = w_ready;
   assign bus.data_out   = r_data;
   assign bus.code_cur   = r_code;
   assign bus.out_valid  = r_valid;
   assign bus.scan_wrap  = r_wrap;

endmodule
